bin_to_bcd_seq: RTL and testbench

- Iterative double-dabble (shift-and-add-3) converter from unsigned binary to packed BCD, one bit per clock.
- Sits directly upstream of the per-digit BCD-to-seven-segment decoder.
- Each 4-bit nibble of bcd_out feeds one decoder instance, so counter and sensor values can be shown on multi-digit displays.
- Uses a start/busy/done handshake.
- Holds the last result stable between conversions.

---
 rtl/bin_to_bcd_seq_if.sv | 22 ++
 rtl/bin_to_bcd_seq.sv | 112 +++++++++++
 tb/tb_bin_to_bcd_seq.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/bin_to_bcd_seq_if.sv
// Start/busy/done handshake and data bus for the sequential binary-to-BCD converter.
interface bin_to_bcd_seq_if #(
    parameter int BIN_W  = 14,
    parameter int DIGITS = 4
);
    logic                  start;
    logic [BIN_W-1:0]      bin_in;
    logic                  busy;
    logic                  done;
    logic [4*DIGITS-1:0]   bcd_out;
    logic                  overflow;

    modport master (
        output start, bin_in,
        input  busy, done, bcd_out, overflow
    );

    modport slave (
        input  start, bin_in,
        output busy, done, bcd_out, overflow
    );
endinterface

// File: rtl/bin_to_bcd_seq.sv
// Iterative double-dabble converter: unsigned binary to packed BCD, one bit per clock.
// Results saturate to all nines with overflow set when the value exceeds 10^DIGITS-1.
module bin_to_bcd_seq #(
    parameter int BIN_W  = 14,
    parameter int DIGITS = 4
) (
    input  logic            clk,
    input  logic            reset,
    bin_to_bcd_seq_if.slave bus
);
    localparam int CNT_W = $clog2(BIN_W + 1);
    localparam int BCD_W = 4 * DIGITS;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    state_t             state_q, state_d;
    logic [BIN_W-1:0]   shift_q, shift_d;
    logic [BCD_W-1:0]   scratch_q, scratch_d;
    logic [BCD_W-1:0]   bcd_q, bcd_d;
    logic               sticky_q, sticky_d;
    logic               ovf_q, ovf_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic [BCD_W-1:0]   adj;
    logic [BCD_W-1:0]   scratch_sh;
    logic [BIN_W-1:0]   shift_sh;
    logic               top_bit;

    // Datapath: per-nibble add-3 (mod 16, no inter-nibble carry), then one-bit left shift.
    always_comb begin
        adj = scratch_q;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (scratch_q[4*i +: 4] >= 4'd5) begin
                adj[4*i +: 4] = scratch_q[4*i +: 4] + 4'd3;
            end
        end
        top_bit    = adj[BCD_W-1];
        scratch_sh = {adj[BCD_W-2:0], shift_q[BIN_W-1]};
        shift_sh   = shift_q << 1;
    end

    // Next-state logic: load on start, iterate BIN_W times, publish the result.
    // The result register is loaded on the final shift edge so that bcd_out and
    // overflow are already valid during the single DONE cycle.
    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        scratch_d = scratch_q;
        sticky_d  = sticky_q;
        cnt_d     = cnt_q;
        bcd_d     = bcd_q;
        ovf_d     = ovf_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    shift_d   = bus.bin_in;
                    scratch_d = '0;
                    sticky_d  = 1'b0;
                    cnt_d     = CNT_W'(BIN_W);
                    state_d   = SHIFT;
                end
            end
            SHIFT: begin
                scratch_d = scratch_sh;
                shift_d   = shift_sh;
                sticky_d  = sticky_q | top_bit;
                cnt_d     = cnt_q - 1'b1;
                if (cnt_q == CNT_W'(1)) begin
                    state_d = DONE;
                    ovf_d   = sticky_d;
                    bcd_d   = sticky_d ? {DIGITS{4'h9}} : scratch_sh;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            shift_q   <= '0;
            scratch_q <= '0;
            sticky_q  <= 1'b0;
            cnt_q     <= '0;
            bcd_q     <= '0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            scratch_q <= scratch_d;
            sticky_q  <= sticky_d;
            cnt_q     <= cnt_d;
            bcd_q     <= bcd_d;
            ovf_q     <= ovf_d;
        end
    end

    assign bus.busy     = (state_q == SHIFT);
    assign bus.done     = (state_q == DONE);
    assign bus.bcd_out  = bcd_q;
    assign bus.overflow = ovf_q;
endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Scoreboard bench for bin_to_bcd_seq: accepted requests push a decimal-arithmetic
// reference result; a negedge monitor pops and compares on every done pulse.
module tb_bin_to_bcd_seq;
    localparam int BIN_W  = 14;
    localparam int DIGITS = 4;
    localparam int BCD_W  = 4 * DIGITS;
    localparam int LAT_T  = 145;  // accept edge to DONE-cycle negedge, 10-unit clock

    logic clk;
    logic reset;
    int   checks;
    int   failures;

    logic [BCD_W:0]    exp_q[$];
    longint unsigned   t_q[$];
    logic [BCD_W-1:0]  last_bcd;
    logic              last_ovf;

    bin_to_bcd_seq_if #(.BIN_W(BIN_W), .DIGITS(DIGITS)) bus ();

    bin_to_bcd_seq #(.BIN_W(BIN_W), .DIGITS(DIGITS)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: decimal digits by division; saturate to all nines above 10^DIGITS-1.
    function automatic logic [BCD_W:0] ref_conv(input int v);
        logic [BCD_W:0] r;
        int d;
        r = '0;
        if (v > 10**DIGITS - 1) begin
            r = {1'b1, {DIGITS{4'h9}}};
        end else begin
            d = v;
            for (int i = 0; i < DIGITS; i++) begin
                r[4*i +: 4] = 4'(d % 10);
                d = d / 10;
            end
        end
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at t=%0t", name, act, req, $time);
        end
    endtask

    // Request monitor: a start seen while the DUT is idle is an accepted conversion.
    always @(posedge clk) begin
        if (!reset && bus.start === 1'b1 && bus.busy === 1'b0 && bus.done === 1'b0) begin
            exp_q.push_back(ref_conv(int'(bus.bin_in)));
            t_q.push_back($time);
        end
    end

    // Response monitor: compare on done, otherwise check busy and result hold.
    always @(negedge clk) begin
        logic [BCD_W:0]  e;
        longint unsigned t;
        if (reset) begin
            exp_q.delete();
            t_q.delete();
            last_bcd = '0;
            last_ovf = 1'b0;
        end else if (bus.done === 1'b1) begin
            check("done_busy_low", 32'(bus.busy), 32'd0);
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL spurious_done actual=done required=no_done at t=%0t", $time);
            end else begin
                e = exp_q.pop_front();
                t = t_q.pop_front();
                check("bcd_out", 32'(bus.bcd_out), 32'(e[BCD_W-1:0]));
                check("overflow", 32'(bus.overflow), 32'(e[BCD_W]));
                check("latency", 32'($time - t), 32'(LAT_T));
                last_bcd = e[BCD_W-1:0];
                last_ovf = e[BCD_W];
            end
        end else begin
            check("busy", 32'(bus.busy), 32'(exp_q.size() != 0));
            check("hold_bcd", 32'(bus.bcd_out), 32'(last_bcd));
            check("hold_ovf", 32'(bus.overflow), 32'(last_ovf));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || bus.busy !== 1'b0 || bus.done !== 1'b0) && n < 200) begin
            tick();
            n++;
        end
        checks++;
        if (n >= 200) begin
            failures++;
            $display("FAIL idle_timeout actual=busy_after_%0d_cycles required=idle", n);
        end
    endtask

    task automatic conv(input int v);
        bus.start  = 1'b1;
        bus.bin_in = BIN_W'(v);
        tick();
        bus.start  = 1'b0;
        bus.bin_in = BIN_W'($urandom);
        wait_idle();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int vals[7] = '{0, 1234, 9999, 7, 10000, 16383, 42};
        checks     = 0;
        failures   = 0;
        last_bcd   = '0;
        last_ovf   = 1'b0;
        reset      = 1'b1;
        bus.start  = 1'b0;
        bus.bin_in = '0;
        repeat (3) tick();
        @(negedge clk);
        check("reset_busy", 32'(bus.busy), 32'd0);
        check("reset_done", 32'(bus.done), 32'd0);
        check("reset_bcd", 32'(bus.bcd_out), 32'd0);
        check("reset_ovf", 32'(bus.overflow), 32'd0);
        tick();
        reset = 1'b0;
        tick();

        // Directed values including zero, max in range, and saturating cases.
        foreach (vals[i]) conv(vals[i]);

        // Start pulsed mid-conversion is ignored; result then holds with start low.
        bus.start  = 1'b1;
        bus.bin_in = BIN_W'(1234);
        tick();
        bus.start  = 1'b0;
        repeat (4) tick();
        bus.start  = 1'b1;
        bus.bin_in = BIN_W'(5678);
        tick();
        bus.start  = 1'b0;
        wait_idle();
        repeat (10) tick();

        // Start held high with bin_in stepping every cycle.
        bus.start = 1'b1;
        for (int i = 0; i < 21 * 16; i++) begin
            bus.bin_in = BIN_W'(i % 21);
            tick();
        end
        bus.start = 1'b0;
        wait_idle();

        // Reset during a conversion aborts it with no done pulse.
        bus.start  = 1'b1;
        bus.bin_in = BIN_W'(9876);
        tick();
        bus.start  = 1'b0;
        repeat (6) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("abort_busy", 32'(bus.busy), 32'd0);
        check("abort_bcd", 32'(bus.bcd_out), 32'd0);
        repeat (20) tick();
        conv(9876);

        // Randomized conversions across the full input range.
        for (int i = 0; i < 150; i++) begin
            repeat ($urandom_range(0, 3)) tick();
            conv(int'($urandom_range(0, 16383)));
        end

        repeat (3) tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
